// File: rtl/vid_pkg.sv
// Shared types and constants for the LCD frame scheduler: FSM states and the
// column/page window header that precedes every frame.
package vid_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StHdr,
    StSync,
    StStart,
    StStream
  } state_e;

  localparam logic [7:0]  OpCaset = 8'h2A;
  localparam logic [7:0]  OpPaset = 8'h2B;
  localparam logic [7:0]  OpRamwr = 8'h2C;
  localparam int unsigned HdrLen  = 11;

  // Header byte as {rs, data}; opcodes go out with rs=0, parameters with rs=1.
  function automatic logic [8:0] hdr_byte(input logic [3:0]  idx,
                                          input logic [15:0] x_end,
                                          input logic [15:0] y_end);
    logic [8:0] b;
    case (idx)
      4'd0:    b = {1'b0, OpCaset};
      4'd3:    b = {1'b1, x_end[15:8]};
      4'd4:    b = {1'b1, x_end[7:0]};
      4'd5:    b = {1'b0, OpPaset};
      4'd8:    b = {1'b1, y_end[15:8]};
      4'd9:    b = {1'b1, y_end[7:0]};
      4'd10:   b = {1'b0, OpRamwr};
      default: b = {1'b1, 8'h00};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/vid_cmd_fifo.sv
// Synchronous FIFO holding queued CPU command bytes {rs, data}; the head entry
// is presented from registered storage so it can drive the PHY directly.
module vid_cmd_fifo #(
  parameter int unsigned FIFO_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] wdata_i,
  input  logic       push_i,
  input  logic       pop_i,
  output logic [8:0] head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       last_o
);
  import vid_pkg::*;

  localparam int unsigned Depth = 2 ** FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] DepthCnt = (FIFO_LOG2 + 1)'(Depth);

  logic [8:0]           mem_q [Depth];
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2:0]   cnt_q, cnt_d;
  logic                 do_push, do_pop;

  assign full_o  = (cnt_q == DepthCnt);
  assign empty_o = (cnt_q == '0);
  assign last_o  = (cnt_q == (FIFO_LOG2 + 1)'(1));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + (FIFO_LOG2 + 1)'(do_push) - (FIFO_LOG2 + 1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vid_frame_sched.sv
// LCD PHY owner arbitration: CPU command bytes between frames, an automatic
// window header before each frame, optional tearing alignment, then pixels.
module vid_frame_sched #(
  parameter int unsigned X_END     = 319,
  parameter int unsigned Y_END     = 239,
  parameter int unsigned FIFO_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctl_run_i,
  input  logic        ctl_vsync_i,
  input  logic        ctl_single_i,
  input  logic        ctl_clr_ovr_i,
  input  logic [8:0]  cmd_data_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        fmark_stb_i,
  output logic        pp_start_o,
  input  logic        pp_active_i,
  input  logic [7:0]  pp_data_i,
  input  logic        pp_valid_i,
  output logic        pp_ready_o,
  output logic [7:0]  phy_data_o,
  output logic        phy_rs_o,
  output logic        phy_valid_o,
  input  logic        phy_ready_i,
  output logic        stat_busy_o,
  output logic [15:0] stat_frame_cnt_o,
  output logic        stat_overrun_o
);
  import vid_pkg::*;

  localparam logic [15:0] XEnd    = 16'(X_END);
  localparam logic [15:0] YEnd    = 16'(Y_END);
  localparam logic [3:0]  HdrLast = 4'(HdrLen - 1);

  state_e      state_q, state_d;
  logic [3:0]  hdr_cnt_q, hdr_cnt_d;
  logic        single_q, single_d;
  logic        first_q, first_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        overrun_q, overrun_d;

  logic [8:0]  fifo_head, hdr_word;
  logic        fifo_full, fifo_empty, fifo_last, fifo_pop;
  logic        phy_hs, cmd_push, req;

  vid_cmd_fifo #(
    .FIFO_LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wdata_i (cmd_data_i),
    .push_i  (cmd_valid_i),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .last_o  (fifo_last)
  );

  assign cmd_ready_o = ~fifo_full;
  assign cmd_push    = cmd_valid_i & ~fifo_full;
  assign phy_hs      = phy_valid_o & phy_ready_i;
  assign req         = ctl_run_i | single_q;
  assign hdr_word    = hdr_byte(hdr_cnt_q, XEnd, YEnd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StCmd;
        else if (req)    state_d = StHdr;
      end
      // A push landing on the final pop keeps us here for the new byte.
      StCmd:    if (phy_hs && fifo_last && !cmd_push) state_d = StIdle;
      StHdr:    if (phy_hs && hdr_cnt_q == HdrLast) state_d = ctl_vsync_i ? StSync : StStart;
      StSync:   if (fmark_stb_i || !ctl_vsync_i) state_d = StStart;
      StStart:  state_d = StStream;
      StStream: if (!first_q && !pp_active_i && !pp_valid_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    phy_data_o  = 8'h00;
    phy_rs_o    = 1'b0;
    phy_valid_o = 1'b0;
    pp_ready_o  = 1'b0;
    pp_start_o  = 1'b0;
    fifo_pop    = 1'b0;
    unique case (state_q)
      StCmd: begin
        {phy_rs_o, phy_data_o} = fifo_head;
        phy_valid_o            = ~fifo_empty;
        fifo_pop               = phy_ready_i;
      end
      StHdr: begin
        {phy_rs_o, phy_data_o} = hdr_word;
        phy_valid_o            = 1'b1;
      end
      StStart: pp_start_o = 1'b1;
      StStream: begin
        phy_data_o  = pp_data_i;
        phy_rs_o    = 1'b1;
        phy_valid_o = pp_valid_i;
        pp_ready_o  = phy_ready_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    hdr_cnt_d   = (state_q == StHdr) ? hdr_cnt_q + 4'(phy_hs) : 4'd0;
    first_d     = (state_q == StStart);
    single_d    = single_q | ctl_single_i;
    if (state_q == StIdle && state_d == StHdr) single_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (state_q == StStream && state_d == StIdle) frame_cnt_d = frame_cnt_q + 16'd1;
    overrun_d = overrun_q & ~ctl_clr_ovr_i;
    if (state_q == StStream && fmark_stb_i && ctl_vsync_i) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt_q   <= 4'd0;
      single_q    <= 1'b0;
      first_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
      overrun_q   <= 1'b0;
    end else begin
      hdr_cnt_q   <= hdr_cnt_d;
      single_q    <= single_d;
      first_q     <= first_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign stat_busy_o      = (state_q != StIdle) | ~fifo_empty;
  assign stat_frame_cnt_o = frame_cnt_q;
  assign stat_overrun_o   = overrun_q;

endmodule

// File: tb/tb_vid_frame_sched.sv
// Directed bench for vid_frame_sched; every PHY byte is checked in order against
// a scoreboard of expected {rs, data} words filled as stimulus is driven.
module tb_vid_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctl_run, ctl_vsync, ctl_single, ctl_clr_ovr;
  logic [8:0]  cmd_data;
  logic        cmd_valid, cmd_ready;
  logic        fmark_stb, pp_start, pp_active;
  logic [7:0]  pp_data;
  logic        pp_valid, pp_ready;
  logic [7:0]  phy_data;
  logic        phy_rs, phy_valid;
  logic        phy_ready = 1'b0;
  logic        stat_busy, stat_overrun;
  logic [15:0] stat_frame_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [8:0]  sb[$];
  logic [8:0]  mon_exp;
  bit          rand_en = 1'b0;
  logic        rdy_fix = 1'b1;
  int          cyc;
  bit          found, saw, hs;

  // Window header for a 320x240 panel.
  logic [8:0] hdr_exp [11] = '{9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F,
                               9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02C};

  vid_frame_sched #(
    .X_END     (319),
    .Y_END     (239),
    .FIFO_LOG2 (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ctl_run_i        (ctl_run),
    .ctl_vsync_i      (ctl_vsync),
    .ctl_single_i     (ctl_single),
    .ctl_clr_ovr_i    (ctl_clr_ovr),
    .cmd_data_i       (cmd_data),
    .cmd_valid_i      (cmd_valid),
    .cmd_ready_o      (cmd_ready),
    .fmark_stb_i      (fmark_stb),
    .pp_start_o       (pp_start),
    .pp_active_i      (pp_active),
    .pp_data_i        (pp_data),
    .pp_valid_i       (pp_valid),
    .pp_ready_o       (pp_ready),
    .phy_data_o       (phy_data),
    .phy_rs_o         (phy_rs),
    .phy_valid_o      (phy_valid),
    .phy_ready_i      (phy_ready),
    .stat_busy_o      (stat_busy),
    .stat_frame_cnt_o (stat_frame_cnt),
    .stat_overrun_o   (stat_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    phy_ready = rand_en ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && phy_valid && phy_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL phy_extra: observed %0h expected no byte", {phy_rs, phy_data});
      end else begin
        mon_exp = sb.pop_front();
        check("phy_byte", 32'({phy_rs, phy_data}), 32'(mon_exp));
      end
    end
  end

  task automatic push_hdr();
    for (int i = 0; i < 11; i++) sb.push_back(hdr_exp[i]);
  endtask

  task automatic push_cmd(input logic [8:0] d, input bit track);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (track) sb.push_back(d);
  endtask

  task automatic pulse_single();
    @(posedge clk); #1 ctl_single = 1'b1;
    @(posedge clk); #1 ctl_single = 1'b0;
  endtask

  task automatic wait_pp_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (pp_start) ok = 1'b1;
    end
  endtask

  // Called at a drive point (just after a rising edge); returns at one.
  task automatic send_pixels(input int n);
    bit got;
    for (int k = 0; k < n; k++) begin
      pp_valid = 1'b1;
      pp_data  = 8'($urandom);
      sb.push_back({1'b1, pp_data});
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk) got = pp_ready;
        @(posedge clk); #1;
      end
      check("pixel_accept", 32'(got), 32'd1);
    end
    pp_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk);
      if (!stat_busy) idle = 1'b1;
    end
    check(tag, 32'(idle), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; ctl_run = 1'b0; ctl_vsync = 1'b0; ctl_single = 1'b0; ctl_clr_ovr = 1'b0;
    cmd_data = '0; cmd_valid = 1'b0; fmark_stb = 1'b0; pp_active = 1'b0;
    pp_data = '0; pp_valid = 1'b0;
    #3;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_phy", 32'({pp_start, pp_ready, phy_valid, phy_rs, phy_data}), 32'd0);
    check("rst_stat", 32'({stat_busy, stat_overrun, stat_frame_cnt}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Command drain.
    push_cmd(9'h011, 1'b1);
    push_cmd(9'h180, 1'b1);
    push_cmd(9'h029, 1'b1);
    wait_idle("drain_idle");
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    check("drain_frame_cnt", 32'(stat_frame_cnt), 32'd0);

    // Single frame with latency measured from the pulse cycle.
    push_hdr();
    @(posedge clk); #1 ctl_single = 1'b1;
    @(posedge clk); #1 ctl_single = 1'b0;
    cyc = 1; found = 1'b0;
    while (!found && cyc < 200) begin
      @(negedge clk);
      if (pp_start) found = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("single_pp_start_seen", 32'(found), 32'd1);
    check("single_latency", 32'(cyc), 32'd13);
    @(posedge clk); #1 pp_active = 1'b1;
    @(negedge clk);
    check("pp_start_one_cycle", 32'(pp_start), 32'd0);
    @(posedge clk); #1;
    send_pixels(2);
    pp_active = 1'b0;
    wait_idle("single_idle");
    check("single_frame_cnt", 32'(stat_frame_cnt), 32'd1);
    check("single_sb_empty", 32'(sb.size()), 32'd0);

    // Vsync alignment and overrun.
    ctl_vsync = 1'b1;
    push_hdr();
    pulse_single();
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pp_start) saw = 1'b1;
    end
    check("vsync_hold", 32'(saw), 32'd0);
    check("vsync_busy", 32'(stat_busy), 32'd1);
    check("vsync_hdr_done", 32'(sb.size()), 32'd0);
    @(posedge clk); #1 fmark_stb = 1'b1;
    @(negedge clk);
    check("vsync_no_early_start", 32'(pp_start), 32'd0);
    @(posedge clk); #1 fmark_stb = 1'b0;
    @(negedge clk);
    check("vsync_start_after_fmark", 32'(pp_start), 32'd1);
    @(posedge clk); #1 pp_active = 1'b1;
    @(posedge clk); #1 fmark_stb = 1'b1;
    @(posedge clk); #1 fmark_stb = 1'b0;
    @(negedge clk);
    check("overrun_set", 32'(stat_overrun), 32'd1);
    @(posedge clk); #1 ctl_clr_ovr = 1'b1;
    @(posedge clk); #1 ctl_clr_ovr = 1'b0;
    @(negedge clk);
    check("overrun_clr", 32'(stat_overrun), 32'd0);
    @(posedge clk); #1 begin fmark_stb = 1'b1; ctl_clr_ovr = 1'b1; end
    @(posedge clk); #1 begin fmark_stb = 1'b0; ctl_clr_ovr = 1'b0; end
    @(negedge clk);
    check("overrun_set_wins", 32'(stat_overrun), 32'd1);
    @(posedge clk); #1 ctl_clr_ovr = 1'b1;
    @(posedge clk); #1 ctl_clr_ovr = 1'b0;
    send_pixels(1);
    pp_active = 1'b0;
    wait_idle("vsync_idle");
    check("vsync_frame_cnt", 32'(stat_frame_cnt), 32'd2);
    check("overrun_clr2", 32'(stat_overrun), 32'd0);
    ctl_vsync = 1'b0;

    // Arbitration: CPU byte queued mid-frame goes out before the next header.
    push_hdr();
    pulse_single();
    wait_pp_start(found);
    check("arb_start3", 32'(found), 32'd1);
    @(posedge clk); #1 begin pp_active = 1'b1; ctl_run = 1'b1; end
    push_cmd(9'h155, 1'b0);
    send_pixels(2);
    sb.push_back(9'h155);
    push_hdr();
    pp_active = 1'b0;
    wait_pp_start(found);
    check("arb_start4", 32'(found), 32'd1);
    check("arb_frame_cnt3", 32'(stat_frame_cnt), 32'd3);
    check("arb_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1 begin pp_active = 1'b1; ctl_run = 1'b0; end
    send_pixels(1);
    pp_active = 1'b0;
    wait_idle("arb_idle");
    check("arb_frame_cnt4", 32'(stat_frame_cnt), 32'd4);

    // Backpressure: fill the FIFO with the PHY stalled, then drain randomly.
    rdy_fix = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("fifo_ready_before_full", 32'(cmd_ready), 32'd1);
      push_cmd(9'($urandom), 1'b1);
    end
    check("fifo_full_ready_low", 32'(cmd_ready), 32'd0);
    check("fifo_stalled_valid", 32'(phy_valid), 32'd1);
    rand_en = 1'b1;
    wait_idle("bp_idle");
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Frame with random PHY backpressure.
    push_hdr();
    pulse_single();
    wait_pp_start(found);
    check("rand_start", 32'(found), 32'd1);
    @(posedge clk); #1 pp_active = 1'b1;
    send_pixels(4);
    pp_active = 1'b0;
    wait_idle("rand_idle");
    check("rand_frame_cnt", 32'(stat_frame_cnt), 32'd5);
    check("rand_sb_empty", 32'(sb.size()), 32'd0);
    rand_en = 1'b0;
    rdy_fix = 1'b1;
    repeat (2) @(posedge clk);

    // Empty frame: the guard keeps STREAM for two cycles.
    push_hdr();
    pulse_single();
    wait_pp_start(found);
    check("guard_start", 32'(found), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("guard_second_cycle_busy", 32'(stat_busy), 32'd1);
    @(negedge clk);
    check("guard_exit_idle", 32'(stat_busy), 32'd0);
    check("guard_frame_cnt", 32'(stat_frame_cnt), 32'd6);

    // Reset while header byte 5 (0x2B) is on the PHY.
    for (int i = 0; i < 5; i++) sb.push_back(hdr_exp[i]);
    pulse_single();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (phy_valid && !phy_rs && phy_data == 8'h2B) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("rst_hdr5_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_phy", 32'({pp_start, pp_ready, phy_valid, phy_rs, phy_data}), 32'd0);
    check("midrst_stat", 32'({stat_busy, stat_overrun, stat_frame_cnt}), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    push_hdr();
    pulse_single();
    wait_pp_start(found);
    check("post_rst_start", 32'(found), 32'd1);
    @(posedge clk); #1 pp_active = 1'b1;
    send_pixels(1);
    pp_active = 1'b0;
    wait_idle("post_rst_idle");
    check("post_rst_frame_cnt", 32'(stat_frame_cnt), 32'd1);
    check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vid_frame_sched.md
# vid_frame_sched

Frame scheduler for the LCD output path. It sits between the CPU command port, the pixel pipeline and the LCD PHY, and decides who owns the PHY byte stream. Queued CPU command bytes are played only between frames. Each frame is preceded by an automatic column/page window header, its start can be aligned to the panel tearing strobe, and pixel bytes are forwarded until the pipeline drains. It replaces ad-hoc CPU kicking of the pixel pipeline and the `force-load` path into the PHY.

## Interface
- `X_END`, 319: last column written into the 0x2A header.
- `Y_END`, 239: last page written into the 0x2B header.
- `FIFO_LOG2`, 4: log2 of the CPU command FIFO depth.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `ctl_run`  in  1  continuous mode: schedule frames back to back.
- `ctl_vsync`  in  1  hold the frame start until `fmark_stb`.
- `ctl_single`  in  1  one-cycle pulse that requests one frame.
- `ctl_clr_ovr`  in  1  clears `stat_overrun`.
- `cmd_data`  in  9  CPU byte, `{rs, data[7:0]}`.
- `cmd_valid`  in  1  CPU byte valid.
- `cmd_ready`  out  1  FIFO not full.
- `fmark_stb`  in  1  one-cycle tearing strobe from the PHY.
- `pp_start`  out  1  one-cycle pixel pipeline start.
- `pp_active`  in  1  pixel pipeline busy.
- `pp_data`  in  8  pixel byte.
- `pp_valid`  in  1  pixel byte valid.
- `pp_ready`  out  1  pixel byte accepted.
- `phy_data`  out  8  byte to the PHY.
- `phy_rs`  out  1  0 = command, 1 = data.
- `phy_valid`  out  1  PHY byte valid.
- `phy_ready`  in  1  PHY accepts the byte.
- `stat_busy`  out  1  state is not IDLE, or the FIFO is non-empty.
- `stat_frame_cnt`  out  16  completed frames, wraps at 0xFFFF -> 0.
- `stat_overrun`  out  1  sticky: a tearing strobe arrived mid-frame in vsync mode.

## Operation
FSM states: IDLE, CMD, HDR, SYNC, START, STREAM.

- **IDLE**
  - FIFO non-empty -> CMD. This has priority over any frame request.
  - Else if `req` -> HDR, where `req` = `ctl_run` OR the latched single request.
  - The single request is latched on `ctl_single` and cleared on entering HDR. Several pulses before HDR still give one frame.
- **CMD**
  - PHY source is the FIFO head; pop on `phy_valid & phy_ready`.
  - Go to IDLE on the cycle the last byte pops, i.e. when the FIFO becomes empty.
  - A push in the same cycle as the final pop keeps the block in CMD.
- **HDR**
  - 4-bit counter emits 11 bytes: 0x2A(rs0), 0x00, 0x00, X_END[15:8], X_END[7:0] (rs1), 0x2B(rs0), 0x00, 0x00, Y_END[15:8], Y_END[7:0] (rs1), 0x2C(rs0).
  - The counter advances only on handshake.
  - After byte 10 is accepted -> SYNC if `ctl_vsync`, else START.
- **SYNC**
  - `fmark_stb` -> START.
  - If `ctl_vsync` drops while waiting -> START.
- **START**
  - `pp_start`=1 for this cycle only -> STREAM.
- **STREAM**
  - `phy_data`/`phy_valid` come from the `pp_*` inputs; `pp_ready` = `phy_ready`.
  - Exit to IDLE when `pp_active`=0 and `pp_valid`=0, but never on the first STREAM cycle (guard flop).
  - `stat_frame_cnt` increments on the exit.
  - `fmark_stb` while in STREAM with `ctl_vsync`=1 sets `stat_overrun`. Set wins over a same-cycle `ctl_clr_ovr`.
- **Outside CMD/HDR/STREAM**: `phy_valid`=0 and `pp_ready`=0. `cmd_ready` depends only on FIFO fullness.

## Timing
- Reset values:
  - state=IDLE; FIFO empty, so `cmd_ready`=1.
  - `pp_start`=0, `pp_ready`=0, `phy_valid`=0, `phy_data`=0, `phy_rs`=0.
  - `stat_frame_cnt`=0, `stat_overrun`=0, `stat_busy`=0, single latch=0.
- Reset mid-frame: the PHY stream stops immediately and the FIFO contents are discarded.
- PHY outputs are a combinational mux of registered sources (FIFO head register, header ROM indexed by the counter, `pp_*` inputs). There is no added latency on the `pp`->`phy` path.
- `phy_valid` stays asserted with stable data until `phy_ready`.
- Latency without vsync:
  - 1 cycle from `ctl_single` to HDR.
  - HDR takes 11 handshakes.
  - START is one cycle.
  - With `phy_ready` held at 1: `pp_start` fires 13 cycles after the `ctl_single` pulse.
- FIFO:
  - Write happens on `cmd_valid & cmd_ready`; `cmd_ready`=0 when full.
  - Simultaneous push/pop when full is not possible, because ready is low.
  - Reading an empty FIFO is a no-op.

## Structure
- Shared package `vid_pkg`:
  - state encoding constants;
  - header opcodes 0x2A/0x2B/0x2C;
  - header length 11.
- Sub-module `vid_cmd_fifo`:
  - 9-bit, 2^`FIFO_LOG2` deep, synchronous FIFO;
  - registered head;
  - full/empty flags.

## Test plan
- **Command drain:** push {0,0x11}, {1,0x80}, {0,0x29} with `phy_ready`=1 -> exactly those 3 bytes on the PHY in order, then IDLE, `stat_busy`=0, `stat_frame_cnt`=0.
- **Single frame:** `ctl_single` pulse with `X_END`=319, `Y_END`=239 -> PHY sees 2A 00 00 01 3F 2B 00 00 00 EF 2C with the listed rs values; one `pp_start` pulse; after 2 pixel bytes and `pp_active` falling, `stat_frame_cnt`=1.
- **Vsync alignment:** `ctl_vsync`=1, `ctl_single` -> no `pp_start` until `fmark_stb`, and `pp_start` follows it by exactly 1 cycle. A second `fmark_stb` during STREAM sets `stat_overrun`; `ctl_clr_ovr` clears it.
- **Arbitration:** push a CPU byte during STREAM -> the byte is not emitted until the frame ends, then it precedes the next frame's 0x2A header in `ctl_run` mode.
- **Backpressure/full:** `phy_ready`=0 with 16 pushes -> `cmd_ready`=0 after the 16th push. Random `phy_ready` toggling -> no byte duplicated or lost, verified by a scoreboard.
- **Reset mid-frame:** assert `rst_n`=0 during HDR byte 5 -> all outputs at their reset values asynchronously; after release, `ctl_single` restarts the header at 0x2A.
